// File: rtl/m_operand_loader_if.sv
// Operand loader bus: raw board inputs in, adder operand pair and load stage out.
interface m_operand_loader_if;
    logic [3:0] sw;
    logic       key_n;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       valid;
    logic [1:0] stage;

    modport master (output sw, key_n, input in1, in2, valid, stage);
    modport slave  (input sw, key_n, output in1, in2, valid, stage);
endinterface

// File: rtl/m_operand_loader.sv
// Loads two 4-bit adder operands from slide switches, one per debounced key press.
// Synchronizes sw/key_n, debounces the key and steps a 3-state load FSM.
module m_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    m_operand_loader_if.slave     bus
);

    localparam int unsigned OP_W = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SHOW   = 2'd2
    } state_t;

    logic [OP_W-1:0]  sw_m;
    logic [OP_W-1:0]  sw_s;
    logic             key_m;
    logic             key_s;
    logic             key_db;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             accept_c;

    state_t           state_q;
    state_t           state_d;
    logic [OP_W-1:0]  in1_q;
    logic [OP_W-1:0]  in1_d;
    logic [OP_W-1:0]  in2_q;
    logic [OP_W-1:0]  in2_d;
    logic             valid_q;
    logic             valid_d;

    // Two-flop synchronizers; key idles released (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m  <= '0;
            sw_s  <= '0;
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sw_m  <= bus.sw;
            sw_s  <= sw_m;
            key_m <= bus.key_n;
            key_s <= key_m;
        end
    end

    // The Nth consecutive differing sample is accepted on this edge
    assign accept_c = (key_s != key_db) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Counter debouncer plus one-cycle press pulse on debounced falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= accept_c && !key_s;
            if (key_s == key_db) begin
                cnt <= '0;
            end else if (accept_c) begin
                key_db <= key_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Load FSM state and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            in1_q   <= '0;
            in2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and capture logic; nothing moves without a press
    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        valid_d = valid_q;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    in1_d   = sw_s;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    in2_d   = sw_s;
                    valid_d = 1'b1;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (press) begin
                    in1_d   = sw_s;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = WAIT_A;
            end
        endcase
    end

    assign bus.in1   = in1_q;
    assign bus.in2   = in2_q;
    assign bus.valid = valid_q;
    assign bus.stage = state_q;

endmodule
